// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_unit
// Description : Instruction prefetcher. Reads words from a local instruction
//               memory at a fetch pointer and queues {pc, word} pairs for a
//               downstream consumer with a valid/ready handshake. Supports
//               redirect (flush and refetch) and halts with a sticky fault
//               when the fetch pointer leaves the memory range.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_unit #(
    parameter int               XLEN       = 32,
    parameter int               IMEM_DEPTH = 32,
    parameter int               QDEPTH     = 4,
    parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_inst,
    output logic [XLEN-1:0]               out_pc,
    output logic [$clog2(QDEPTH):0]       count,
    output logic                          fault
);

    localparam int              c_AW    = $clog2(IMEM_DEPTH);
    localparam int              c_PW    = $clog2(QDEPTH);
    localparam int              c_CW    = c_PW + 1;
    localparam logic [XLEN-1:0] c_DEPTH = XLEN'(IMEM_DEPTH);
    localparam logic [XLEN-1:0] c_FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN = ~XLEN'(3);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(QDEPTH);
    localparam logic [c_PW-1:0] c_PONE  = c_PW'(1);
    localparam logic [c_CW-1:0] c_CONE  = c_CW'(1);

    // Instruction memory (not touched by reset)
    logic [31:0]     r_imem [IMEM_DEPTH];

    // Prefetch queue storage
    logic [31:0]     r_q_inst [QDEPTH];
    logic [XLEN-1:0] r_q_pc   [QDEPTH];

    logic [XLEN-1:0] r_fpc;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_fault;

    logic            w_in_range;
    logic [31:0]     w_fetch_word;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [XLEN-1:0] w_redirect_tgt;

    // Word index is fpc[XLEN-1:2]; compared zero-extended to full width
    assign w_in_range     = ({2'b00, r_fpc[XLEN-1:2]} < c_DEPTH);
    assign w_fetch_word   = r_imem[r_fpc[c_AW+1:2]];
    assign w_full         = (r_count == c_FULL);
    assign w_pop          = out_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still accept
    assign w_push         = !redirect && !r_fault && w_in_range && (!w_full || w_pop);
    assign w_redirect_tgt = redirect_pc & c_ALIGN;

    assign out_valid = (r_count != '0);
    assign out_inst  = out_valid ? r_q_inst[r_rd_ptr] : 32'd0;
    assign out_pc    = out_valid ? r_q_pc[r_rd_ptr]   : '0;
    assign count     = r_count;
    assign fault     = r_fault;

    // Memory write port; a same-cycle fetch sees the pre-write word
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
    end

    // Queue data storage, written at the tail on every push
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_q_inst[r_wr_ptr] <= w_fetch_word;
            r_q_pc[r_wr_ptr]   <= r_fpc;
        end
    end

    // Fetch pointer, queue pointers, occupancy and sticky fault
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fpc    <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_fault  <= 1'b0;
        end else if (redirect) begin
            // Any concurrent pop is absorbed by the flush
            r_fpc    <= w_redirect_tgt;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_fault  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PONE;
                r_fpc    <= r_fpc + c_FOUR;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CONE;
                2'b01:   r_count <= r_count - c_CONE;
                default: r_count <= r_count;
            endcase
            if (!w_in_range) begin
                r_fault <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_unit
// Description : Scoreboard bench for prefetch_unit. Expected {pc, word} pairs
//               are generated from a reference memory when a fetch stream
//               starts (reset or redirect) and compared on each pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_unit;

    localparam int          c_XLEN  = 32;
    localparam int          c_DEPTH = 32;
    localparam int          c_QD    = 4;
    localparam logic [31:0] c_RPC   = 32'h0;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  count;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tb_mem [c_DEPTH];
    logic [63:0] exp_q [$];

    prefetch_unit #(
        .XLEN       (c_XLEN),
        .IMEM_DEPTH (c_DEPTH),
        .QDEPTH     (c_QD),
        .RESET_PC   (c_RPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .count       (count),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Expected stream from an aligned start address up to the end of memory
    function automatic void build(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        for (int k = 0; k < c_DEPTH; k++) begin
            pc = (start & ~32'd3) + 32'(4 * k);
            if ((pc >> 2) >= 32'(c_DEPTH)) break;
            exp_q.push_back({pc, tb_mem[pc[6:2]]});
        end
    endfunction

    // Scoreboard: compare pops, track memory writes, restart stream on flush
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && out_valid && out_ready) begin
            check("sb_avail", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pop_pc", 64'(out_pc), 64'(e[63:32]));
                check("pop_inst", 64'(out_inst), 64'(e[31:0]));
            end
        end
        if (imem_we) tb_mem[imem_waddr] = imem_wdata;
        if (!rst) build(c_RPC);
        else if (redirect) build(redirect_pc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; out_ready = 1'b0;
        step();
        // Load memory while held in reset
        for (int i = 0; i < c_DEPTH; i++) begin
            imem_we = 1'b1; imem_waddr = 5'(i); imem_wdata = 32'h100 + 32'(i);
            step();
        end
        imem_we = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_inst", 64'(out_inst), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);

        // Fill then drain
        rst = 1'b1;
        step();
        check("fill_first", 64'(count), 64'd1);
        check("fill_first_pc", 64'(out_pc), 64'(c_RPC));
        repeat (3) step();
        check("fill_full", 64'(count), 64'd4);
        repeat (2) step();
        check("fill_hold", 64'(count), 64'd4);
        check("fill_head_inst", 64'(out_inst), 64'h100);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("drain_count", 64'(count), 64'd4);
        end

        // Redirect with concurrent pop on a full queue
        out_ready = 1'b0;
        repeat (4) step();
        check("pre_redir_full", 64'(count), 64'd4);
        redirect = 1'b1; redirect_pc = 32'h0E; out_ready = 1'b1;
        step();
        redirect = 1'b0; out_ready = 1'b0;
        check("redir_flush", 64'(out_valid), 64'd0);
        step();
        check("redir_valid", 64'(out_valid), 64'd1);
        check("redir_pc", 64'(out_pc), 64'h0C);
        check("redir_inst", 64'(out_inst), 64'h103);

        // Run off the end of memory
        redirect = 1'b1; redirect_pc = 32'h78; out_ready = 1'b1;
        step();
        redirect = 1'b0;
        step();
        check("oor_fault_n1", 64'(fault), 64'd0);
        step();
        check("oor_fault_n2", 64'(fault), 64'd0);
        step();
        check("oor_fault_n3", 64'(fault), 64'd1);
        repeat (4) step();
        check("oor_no_valid", 64'(out_valid), 64'd0);
        check("oor_sticky", 64'(fault), 64'd1);
        check("oor_all_seen", 64'(exp_q.size()), 64'd0);
        redirect = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        step();
        redirect = 1'b0;
        check("oor_clear", 64'(fault), 64'd0);

        // Reset mid-stream
        repeat (3) step();
        check("mid_count3", 64'(count), 64'd3);
        rst = 1'b0;
        step();
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        step();
        check("mid_resume_valid", 64'(out_valid), 64'd1);
        check("mid_resume_pc", 64'(out_pc), 64'(c_RPC));

        // Write/fetch collision on the word being fetched
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        imem_we = 1'b1; imem_waddr = 5'd8; imem_wdata = 32'hDEADBEEF;
        step();
        imem_we = 1'b0;
        check("coll_pc", 64'(out_pc), 64'h20);
        check("coll_old", 64'(out_inst), 64'h108);
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        check("coll_flush", 64'(out_valid), 64'd0);
        step();
        check("coll_new_pc", 64'(out_pc), 64'h20);
        check("coll_new", 64'(out_inst), 64'hDEADBEEF);

        // Random consumer backpressure with occasional redirects
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                redirect = 1'b1;
                redirect_pc = 32'($urandom_range(0, 32'h9F));
            end
            step();
            redirect = 1'b0;
        end
        out_ready = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
